// File: rtl/ones_run_tx_pkg.sv
// Shared definitions for the ones-run transmitter and its zero-detector companions.
package ones_run_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TERM = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  localparam int unsigned LEN_W_DEF      = 4;
  localparam int unsigned GAP_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF      = 8;

  // Gap counter width; never zero so the type stays legal when the gap is disabled.
  function automatic int unsigned gap_cnt_w(input int unsigned gap);
    return (gap == 0) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/ones_run_tx_if.sv
// Length handshake plus serial-line outputs of the ones-run transmitter.
interface ones_run_tx_if
  import ones_run_tx_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic [LEN_W-1:0] len_in;
  logic             len_valid;
  logic             len_ready;
  logic             x_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output len_in, len_valid,
    input  len_ready, x_out, busy, done, frame_cnt
  );

  modport slave (
    input  len_in, len_valid,
    output len_ready, x_out, busy, done, frame_cnt
  );
endinterface

// File: rtl/ones_run_tx_down_counter.sv
// Loadable down-counter with zero/one flags; saturates at zero.
module tx_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero,
  output logic         is_one
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == W'(1));
endmodule

// File: rtl/ones_run_tx.sv
// Serial source: on each accepted length N drives N ones, one zero terminator,
// then GAP_CYCLES idle zeros.
module ones_run_tx
  import ones_run_tx_pkg::*;
#(
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  ones_run_tx_if.slave bus
);
  localparam int unsigned GW = gap_cnt_w(GAP_CYCLES);

  tx_state_e state, nxt;
  logic      accept;
  logic      run_one, run_zero, run_done;
  logic      gap_done;

  assign bus.len_ready = reset & (state == ST_IDLE);
  assign accept        = bus.len_valid & bus.len_ready;

  tx_down_counter #(.W(LEN_W)) u_run_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.len_in),
    .dec      (state == ST_RUN),
    .is_zero  (run_zero),
    .is_one   (run_one)
  );
  // Zero can only be reached after an abnormal entry into RUN; treat it as end of run.
  assign run_done = run_one | run_zero;

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      logic gap_one, gap_zero;
      tx_down_counter #(.W(GW)) u_gap_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (state == ST_TERM),
        .load_val (GW'(GAP_CYCLES)),
        .dec      (state == ST_GAP),
        .is_zero  (gap_zero),
        .is_one   (gap_one)
      );
      assign gap_done = gap_one | gap_zero;
    end else begin : g_nogap
      assign gap_done = 1'b1;
    end
  endgenerate

  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: if (accept) nxt = (bus.len_in != '0) ? ST_RUN : ST_TERM;
      ST_RUN:  nxt = run_done ? ST_TERM : ST_RUN;
      ST_TERM: nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  nxt = gap_done ? ST_IDLE : ST_GAP;
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the destination state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bus.x_out     <= 1'b0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      state     <= nxt;
      bus.x_out <= (nxt == ST_RUN);
      bus.done  <= (nxt == ST_TERM);
      bus.busy  <= (nxt != ST_IDLE);
      if (nxt == ST_TERM) bus.frame_cnt <= bus.frame_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ones_run_tx.sv
// Scoreboard bench for ones_run_tx with a chained Mealy zero-detector model.
module tb_ones_run_tx;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic x;
    logic done;
    logic det;
    logic busy;
  } ent_t;

  logic clock;
  logic reset;

  ones_run_tx_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  ones_run_tx #(.LEN_W(LEN_W), .GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  ent_t        q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic        prev_x = 1'b0;
  logic        wrapped = 1'b0;
  int unsigned acc_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle monitor: compares the current line cycle, then books a new frame
  // if the upcoming edge will accept one.
  always @(negedge clock) begin
    ent_t e;
    logic exp_ready;
    logic y;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    if (e.done) begin
      exp_cnt = exp_cnt + CNT_W'(1);
      if (exp_cnt == '0) wrapped = 1'b1;
    end
    exp_ready = reset & ~e.busy;
    y = prev_x & ~bus.x_out;
    chk("x_out",     bus.x_out,     e.x);
    chk("done",      bus.done,      e.done);
    chk("busy",      bus.busy,      e.busy);
    chk("len_ready", bus.len_ready, exp_ready);
    chk("frame_cnt", bus.frame_cnt, exp_cnt);
    chk("det_y",     y,             e.det);
    prev_x = reset ? bus.x_out : 1'b0;
    if (bus.len_valid && exp_ready) begin
      for (int unsigned i = 0; i < bus.len_in; i++) q.push_back('{x:1'b1, done:1'b0, det:1'b0, busy:1'b1});
      q.push_back('{x:1'b0, done:1'b1, det:(bus.len_in != '0), busy:1'b1});
      for (int unsigned i = 0; i < GAP; i++) q.push_back('{x:1'b0, done:1'b0, det:1'b0, busy:1'b1});
      acc_cnt++;
    end
  end

  task automatic send(input int unsigned n, input int unsigned hold);
    int unsigned start;
    logic got;
    start = acc_cnt;
    got = 1'b0;
    bus.len_in    = LEN_W'(n);
    bus.len_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clock);
      if (acc_cnt != start) got = 1'b1;
    end
    chk("accept_timeout", got, 1);
    #1;
    bus.len_in = LEN_W'($urandom);
    if (hold > 0) begin
      repeat (hold) @(posedge clock);
      #1;
    end
    bus.len_valid = 1'b0;
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(posedge clock);
      if (q.size() == 0) idle = 1'b1;
    end
    chk("drain_timeout", idle, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.len_in    = '0;
    bus.len_valid = 1'b0;
    #1 reset = 1'b0;
    // Reset held with a valid length offered: nothing may start.
    bus.len_valid = 1'b1;
    bus.len_in    = LEN_W'(7);
    repeat (4) @(posedge clock);
    #1;
    bus.len_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    send(3, 0);
    drain();
    send(0, 0);
    drain();
    send(15, 10);
    drain();

    // Async reset in the second RUN cycle of a 5-long run.
    send(5, 0);
    @(posedge clock);
    #6;
    reset = 1'b0;
    q.delete();
    prev_x  = 1'b0;
    exp_cnt = '0;
    #1;
    chk("rst_x_out",     bus.x_out,     0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_done",      bus.done,      0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_len_ready", bus.len_ready, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    send(5, 0);
    drain();

    for (int k = 0; k < 300; k++) begin
      send($urandom_range(0, 15), 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    drain();
    chk("cnt_wrapped", wrapped, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
